mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 141 ++++++++++++++
 tb/tb_mdu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit: 32-bit MULT/MULTU/DIV/DIVU with a fixed 33-edge latency.
// Magnitudes are iterated one bit per cycle; signs are reapplied in a final FIX cycle.
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mdcont,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t            state, state_nxt;
  logic [4:0]        cnt;
  logic              op_div, neg_q, neg_r, div_zero;
  logic [DATA_W-1:0] a_cap, b_mag;
  logic [DATA_W-1:0] acc, qr;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   rem_sh;
  logic              div_ge;
  logic [DATA_W-1:0] div_diff;

  // Two's-complement negate when neg is set.
  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v, input logic neg);
    logic signed [DATA_W-1:0] s;
    s = $signed(v);
    if (neg) s = -s;
    return $unsigned(s);
  endfunction

  // 64-bit variant for the product.
  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v, input logic neg);
    logic signed [2*DATA_W-1:0] s;
    s = $signed(v);
    if (neg) s = -s;
    return $unsigned(s);
  endfunction

  // Magnitude of an operand; unsigned ops pass through untouched.
  function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v, input logic sgn);
    return neg32(v, sgn & v[DATA_W-1]);
  endfunction

  assign busy = (state != IDLE);

  // State, iteration counter and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      if (state == ITER) cnt <= cnt + 5'd1;
      else               cnt <= '0;
    end
  end

  // Next-state: 32 ITER cycles then one FIX cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, b_mag} : '0);
    rem_sh   = {acc, qr[DATA_W-1]};
    div_ge   = (rem_sh >= {1'b0, b_mag});
    div_diff = rem_sh[DATA_W-1:0] - b_mag;
  end

  // Operand capture and iteration registers; qr holds multiplier / dividend-then-quotient.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (start) begin
        op_div   <= mdcont[1];
        neg_q    <= ~mdcont[0] & (rd1[DATA_W-1] ^ rd2[DATA_W-1]);
        neg_r    <= ~mdcont[0] & rd1[DATA_W-1];
        div_zero <= mdcont[1] & (rd2 == '0);
        a_cap    <= rd1;
        b_mag    <= mag32(rd2, ~mdcont[0]);
        qr       <= mag32(rd1, ~mdcont[0]);
        acc      <= '0;
      end
    end else if (state == ITER) begin
      if (op_div) begin
        if (div_ge) begin
          acc <= div_diff;
          qr  <= {qr[DATA_W-2:0], 1'b1};
        end else begin
          acc <= rem_sh[DATA_W-1:0];
          qr  <= {qr[DATA_W-2:0], 1'b0};
        end
      end else begin
        acc <= mul_sum[DATA_W:1];
        qr  <= {mul_sum[0], qr[DATA_W-1:1]};
      end
    end
  end

  // HI/LO: software writes in IDLE, sign-corrected result in FIX, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      if (wr_hi) hi <= wd;
      if (wr_lo) lo <= wd;
    end else if (state == FIX) begin
      if (op_div) begin
        if (div_zero) begin
          hi <= a_cap;
          lo <= '1;
        end else begin
          hi <= neg32(acc, neg_r);
          lo <= neg32(qr, neg_q);
        end
      end else begin
        {hi, lo} <= neg64({acc, qr}, neg_q);
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu: directed vector table, hand-written corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset, start, wr_hi, wr_lo;
  logic [1:0]  mdcont;
  logic [31:0] rd1, rd2, wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[10];

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .mdcont(mdcont),
    .rd1(rd1), .rd2(rd2), .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: u = sa * sb;
      2'd1: u = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) u = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          u = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) u = {a, 32'hFFFFFFFF};
        else        u = {a % b, a / b};
      end
    endcase
    return u;
  endfunction

  // Issue one op, count edges to done, check result, busy and hi/lo hold.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp,
                       input bit disturb, input bit wr_first);
    logic [31:0] hi0, lo0;
    int          lat;
    bit          held, busy_ok;
    @(negedge clk);
    start = 1'b1; mdcont = op; rd1 = a; rd2 = b;
    hi0 = hi; lo0 = lo;
    if (wr_first) begin
      wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'hA5A50F0F;
      hi0 = wd; lo0 = wd;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    rd1 = $urandom; rd2 = $urandom; mdcont = op ^ 2'b11;
    lat = 0; held = 1'b1; busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      if (disturb && lat == 5) begin
        start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'hDEADBEEF;
        mdcont = 2'b01; rd1 = 32'h1; rd2 = 32'h1;
      end
      if (lat == 7) begin
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " result"}, {hi, lo}, exp);
    check({name, " busy/hold"}, {61'd0, busy_ok, held, busy}, {61'd0, 3'b110});
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel;
    bit          quiet;

    vecs[0] = '{"multu_max",   2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_neg3x7", 2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"mult_minsq",  2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{"div_neg7_2",  2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"divu_7_2",    2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5] = '{"div_ovf",     2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{"divu_5_0",    2'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[7] = '{"div_neg7_0",  2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{"div_7_neg2",  2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{"mult_zero",   2'd0, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};

    reset = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    mdcont = 2'd0; rd1 = '0; rd2 = '0; wd = '0;
    #2 reset = 1'b1;
    #1;
    check("reset hi/lo", {hi, lo}, 64'd0);
    check("reset ctl", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle quiet", {62'd0, busy, done}, 64'd0);

    // MTHI, MTLO, then both together
    @(negedge clk); wr_hi = 1'b1; wd = 32'h12345678;
    @(posedge clk); #1 wr_hi = 1'b0;
    check("mthi", {hi, lo}, {32'h12345678, 32'h00000000});
    @(negedge clk); wr_lo = 1'b1; wd = 32'hCAFEF00D;
    @(posedge clk); #1 wr_lo = 1'b0;
    check("mtlo", {hi, lo}, {32'h12345678, 32'hCAFEF00D});
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'h0BADF00D;
    @(posedge clk); #1 begin wr_hi = 1'b0; wr_lo = 1'b0; end
    check("mthi+mtlo", {hi, lo}, {32'h0BADF00D, 32'h0BADF00D});

    // Directed table; consecutive entries start on each other's done cycle
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].ehi, vecs[i].elo}, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("done width", {63'd0, done}, 64'd0);

    do_op("busy_ignore", 2'd1, 32'd3, 32'd5, 64'd15, 1'b1, 1'b0);
    do_op("wr_with_start", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1);

    // Reset at E10 of a MULTU aborts it silently
    @(negedge clk);
    start = 1'b1; mdcont = 2'd1; rd1 = 32'hFFFFFFFF; rd2 = 32'hFFFFFFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort hi/lo", {hi, lo}, 64'd0);
    check("abort ctl", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #3 reset = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy || hi != 0 || lo != 0) quiet = 1'b0;
    end
    check("abort no done", {63'd0, quiet}, 64'd1);

    // Short reset pulse, then start on the first edge after release, then back-to-back
    @(posedge clk); #1 reset = 1'b1;
    #2 reset = 1'b0;
    do_op("after_reset", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 1'b0, 1'b0);
    do_op("back_to_back", 2'd0, 32'hFFFFFFFD, 32'h00000007, {32'hFFFFFFFF, 32'hFFFFFFEB}, 1'b0, 1'b0);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = $urandom_range(1, 15);
      if (sel == 2) a = 32'h80000000;
      if (sel == 3) b = 32'hFFFFFFFF;
      if (sel == 4) a = $urandom_range(0, 255);
      do_op("rand", op, a, b, ref_op(op, a, b), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
